// File: rtl/kbd_event_scheduler.sv
// Shares the key-matrix write port between live PS/2 key events and a FIFO of injected keystrokes.
// Live writes land 1 cycle after ps2_valid and always win. Injected writes retry on collision. inj_ready drops when the FIFO is full.
module kbd_event_scheduler #(
    parameter int HOLD_CYCLES = 100000,
    parameter int GAP_CYCLES  = 100000,
    parameter int CNT_W       = 24,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_valid,
    input  logic [3:0] ps2_row,
    input  logic [2:0] ps2_col,
    input  logic       ps2_pressed,
    input  logic       inj_valid,
    input  logic [3:0] inj_row,
    input  logic [2:0] inj_col,
    output logic       inj_ready,
    input  logic       inj_abort,
    output logic       inj_busy,
    output logic       mat_we,
    output logic [3:0] mat_row,
    output logic [2:0] mat_col,
    output logic       mat_pressed
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, PRESS, HOLD, RELEASE, GAP} state_t;

    state_t           state, state_nx;
    logic [6:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    logic [3:0]       head_row;
    logic [2:0]       head_col;
    logic             head_ok;
    logic [3:0]       cur_row, cur_row_nx;
    logic [2:0]       cur_col, cur_col_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             idle_settled;
    logic             seq_req, seq_pressed;
    logic             grant, live_ok;

    assign inj_ready = (count != FULL_CNT);
    assign inj_busy  = (count != '0) || (state != IDLE);
    assign push      = inj_valid && inj_ready && !inj_abort;
    assign head_row  = fifo_mem[rd_ptr][6:3];
    assign head_col  = fifo_mem[rd_ptr][2:0];
    assign head_ok   = (head_row <= 4'd13) && (head_col != 3'd7);
    assign live_ok   = ps2_valid && (ps2_row <= 4'd13) && (ps2_col != 3'd7);
    // Any live pulse owns the port, even one that is dropped as out of range.
    assign grant     = !ps2_valid;

    always_ff @(posedge clk) begin
        if (reset || inj_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {inj_row, inj_col};
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cur_row_nx  = cur_row;
        cur_col_nx  = cur_col;
        pop         = 1'b0;
        seq_req     = 1'b0;
        seq_pressed = 1'b0;
        case (state)
            IDLE: begin
                // The first IDLE cycle after a keystroke is a settle cycle.
                if (!inj_abort && count != '0 && idle_settled) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        cur_row_nx = head_row;
                        cur_col_nx = head_col;
                        state_nx   = PRESS;
                    end
                end
            end
            PRESS: begin
                seq_req     = 1'b1;
                seq_pressed = 1'b1;
                if (grant) begin
                    state_nx = inj_abort ? RELEASE : HOLD;
                    cnt_nx   = HOLD_LOAD;
                end else if (inj_abort) begin
                    state_nx = IDLE;
                end
            end
            HOLD: begin
                if (inj_abort || cnt == '0)
                    state_nx = RELEASE;
                else
                    cnt_nx = cnt - CNT_W'(1);
            end
            RELEASE: begin
                seq_req = 1'b1;
                if (grant) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LOAD;
                end
            end
            GAP: begin
                if (inj_abort || cnt == '0)
                    state_nx = IDLE;
                else
                    cnt_nx = cnt - CNT_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cur_row      <= '0;
            cur_col      <= '0;
            idle_settled <= 1'b1;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            cur_row      <= cur_row_nx;
            cur_col      <= cur_col_nx;
            idle_settled <= (state == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mat_we      <= 1'b0;
            mat_row     <= '0;
            mat_col     <= '0;
            mat_pressed <= 1'b0;
        end else begin
            mat_we <= live_ok || (seq_req && grant);
            if (live_ok) begin
                mat_row     <= ps2_row;
                mat_col     <= ps2_col;
                mat_pressed <= ps2_pressed;
            end else if (seq_req && grant) begin
                mat_row     <= cur_row;
                mat_col     <= cur_col;
                mat_pressed <= seq_pressed;
            end
        end
    end
endmodule

// File: tb/tb_kbd_event_scheduler.sv
// Scoreboarded bench for kbd_event_scheduler: each phase's expected matrix writes come from a timeline model
// built on the keystroke timing rules; a negedge monitor pops and compares every mat_we pulse.
module tb_kbd_event_scheduler;
    localparam int HOLD   = 4;
    localparam int GAP    = 3;
    localparam int DEPTH  = 16;
    localparam int PH_MAX = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_valid = 1'b0, ps2_pressed = 1'b0;
    logic [3:0] ps2_row = '0, inj_row = '0;
    logic [2:0] ps2_col = '0, inj_col = '0;
    logic       inj_valid = 1'b0, inj_abort = 1'b0;
    logic       inj_ready, inj_busy, mat_we, mat_pressed;
    logic [3:0] mat_row;
    logic [2:0] mat_col;

    kbd_event_scheduler #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ps2_valid(ps2_valid), .ps2_row(ps2_row), .ps2_col(ps2_col), .ps2_pressed(ps2_pressed),
        .inj_valid(inj_valid), .inj_row(inj_row), .inj_col(inj_col), .inj_ready(inj_ready),
        .inj_abort(inj_abort), .inj_busy(inj_busy),
        .mat_we(mat_we), .mat_row(mat_row), .mat_col(mat_col), .mat_pressed(mat_pressed)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [3:0] row; logic [2:0] col; logic pr; } wr_t;
    typedef struct { int offer; int off; int acc; logic [3:0] row; logic [2:0] col; } ent_t;

    wr_t  exp_q[$];
    wr_t  ph_q[$];
    ent_t ents[$];
    logic       live_v   [PH_MAX];
    logic [3:0] live_row [PH_MAX];
    logic [2:0] live_col [PH_MAX];
    logic       live_pr  [PH_MAX];
    int cyc = 0, tests = 0, fails = 0;
    int base, abort_at, reset_at, busy_fall, ph_len;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mat_we === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL write at cycle %0d: got row=%0d col=%0d pr=%0d, expected no write",
                         cyc, mat_row, mat_col, mat_pressed);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.row !== mat_row || e.col !== mat_col || e.pr !== mat_pressed) begin
                    fails++;
                    $display("FAIL write: got cyc=%0d row=%0d col=%0d pr=%0d, expected cyc=%0d row=%0d col=%0d pr=%0d",
                             cyc, mat_row, mat_col, mat_pressed, e.cyc, e.row, e.col, e.pr);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            wr_t e;
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL write missing: got none at cycle %0d, expected cyc=%0d row=%0d col=%0d pr=%0d",
                     cyc, e.cyc, e.row, e.col, e.pr);
        end
    end

    function automatic bit is_live(int c);
        int t = c - base;
        return (t >= 0 && t < PH_MAX) ? live_v[t] : 1'b0;
    endfunction

    function automatic int next_free(int c);
        int x = c;
        while (is_live(x)) x++;
        return x;
    endfunction

    function automatic void add_exp(int c, logic [3:0] r, logic [2:0] cl, logic p);
        wr_t w;
        int i;
        w.cyc = c; w.row = r; w.col = cl; w.pr = p;
        i = ph_q.size();
        while (i > 0 && ph_q[i-1].cyc > c) i--;
        ph_q.insert(i, w);
    endfunction

    // Keystroke timeline: pop one cycle after acceptance once the sequencer is settled, press on the first
    // collision-free cycle, release HOLD cycles later, next pop GAP+2 cycles after the release grant.
    function automatic void model(int span);
        int pops[$];
        int t_ready = base, prev_acc = base - 1;
        ph_q.delete();
        busy_fall = -1;
        for (int t = 0; t < PH_MAX; t++)
            if (live_v[t] && live_row[t] <= 13 && live_col[t] <= 6)
                add_exp(base + t + 1, live_row[t], live_col[t], live_pr[t]);
        for (int k = 0; k < ents.size(); k++) begin
            ent_t e;
            int o, a, c, w, rs, r;
            e = ents[k];
            o = (base + e.offer > prev_acc + 1) ? base + e.offer : prev_acc + 1;
            a = o;
            if (k >= DEPTH && pops[k-DEPTH] + 1 > a) a = pops[k-DEPTH] + 1;
            e.off = o; e.acc = a; ents[k] = e;
            prev_acc = a;
            c = (a + 1 > t_ready) ? a + 1 : t_ready;
            pops.push_back(c);
            if (abort_at >= 0 && c >= abort_at) continue;
            if (e.row > 13 || e.col > 6) begin
                t_ready = c + 1;
                busy_fall = c + 1;
                continue;
            end
            w = next_free(c + 1);
            add_exp(w + 1, e.row, e.col, 1'b1);
            rs = w + 1 + HOLD;
            if (abort_at > w && abort_at <= w + HOLD) rs = abort_at + 1;
            r = next_free(rs);
            add_exp(r + 1, e.row, e.col, 1'b0);
            t_ready = r + GAP + 2;
            busy_fall = r + 1 + GAP;
        end
        ph_len = span;
        if (t_ready - base + 3 > ph_len) ph_len = t_ready - base + 3;
        if (ph_q.size() > 0 && ph_q[ph_q.size()-1].cyc - base + 2 > ph_len)
            ph_len = ph_q[ph_q.size()-1].cyc - base + 2;
    endfunction

    task automatic clear_phase();
        for (int t = 0; t < PH_MAX; t++) begin
            live_v[t] = 1'b0; live_row[t] = '0; live_col[t] = '0; live_pr[t] = 1'b0;
        end
        ents.delete();
        abort_at = -1;
        reset_at = -1;
    endtask

    task automatic add_live(int t, int r, int c, bit p);
        live_v[t] = 1'b1; live_row[t] = 4'(r); live_col[t] = 3'(c); live_pr[t] = p;
    endtask

    task automatic add_ent(int offer, int r, int c);
        ent_t e;
        e.offer = offer; e.off = 0; e.acc = 0; e.row = 4'(r); e.col = 3'(c);
        ents.push_back(e);
    endtask

    task automatic drive_phase();
        int k = 0;
        foreach (ph_q[i]) exp_q.push_back(ph_q[i]);
        for (int t = 0; t < ph_len; t++) begin
            ps2_valid   = (t < PH_MAX) ? live_v[t] : 1'b0;
            ps2_row     = (t < PH_MAX) ? live_row[t] : 4'd0;
            ps2_col     = (t < PH_MAX) ? live_col[t] : 3'd0;
            ps2_pressed = (t < PH_MAX) ? live_pr[t] : 1'b0;
            while (k < ents.size() && ents[k].acc < cyc) k++;
            inj_valid = (k < ents.size()) && (ents[k].off <= cyc);
            inj_row   = (k < ents.size()) ? ents[k].row : 4'd0;
            inj_col   = (k < ents.size()) ? ents[k].col : 3'd0;
            inj_abort = (cyc == abort_at);
            reset     = (cyc == reset_at);
            if (inj_valid) check("inj_ready", inj_ready, cyc == ents[k].acc);
            if (busy_fall >= 0 && cyc == busy_fall - 1) check("inj_busy_before_idle", inj_busy, 1);
            if (busy_fall >= 0 && cyc == busy_fall) check("inj_busy_at_idle", inj_busy, 0);
            @(posedge clk); #1;
        end
        ps2_valid = 1'b0; inj_valid = 1'b0; inj_abort = 1'b0; reset = 1'b0;
    endtask

    task automatic run_phase(int span);
        base = cyc;
        model(span);
        drive_phase();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_mat_we", mat_we, 0);
        check("reset_mat_row", mat_row, 0);
        check("reset_mat_col", mat_col, 0);
        check("reset_mat_pressed", mat_pressed, 0);
        check("reset_inj_ready", inj_ready, 1);
        check("reset_inj_busy", inj_busy, 0);
        repeat (6) begin @(posedge clk); #1; end

        clear_phase();                       // single live make
        add_live(0, 3, 5, 1);
        run_phase(6);

        clear_phase();                       // lone injected key
        add_ent(0, 7, 4);
        run_phase(4);

        clear_phase();                       // injected key colliding with live pulses
        add_ent(0, 7, 4);
        add_live(2, 0, 0, 1);
        add_live(3, 13, 6, 0);
        run_phase(4);

        clear_phase();                       // FIFO fill while press is stalled by out-of-range live traffic
        add_ent(0, 2, 1);
        for (int i = 1; i <= 17; i++) add_ent(1, i % 14, i % 7);
        for (int t = 2; t < 30; t++) add_live(t, 15, 0, 1);
        run_phase(32);

        clear_phase();                       // out-of-range injected entries are discarded
        add_ent(0, 14, 0);
        add_ent(0, 3, 7);
        add_ent(0, 5, 6);
        add_ent(0, 13, 6);
        run_phase(4);

        clear_phase();                       // abort during HOLD with five entries queued
        add_ent(0, 9, 2);
        for (int i = 1; i <= 5; i++) add_ent(1, i, i);
        add_live(2, 1, 0, 1);
        add_live(3, 2, 1, 0);
        add_live(4, 3, 2, 1);
        abort_at = cyc + 7;
        run_phase(10);

        clear_phase();                       // reset in mid-HOLD: press only, no release
        add_ent(0, 6, 3);
        base = cyc;
        reset_at = base + 5;
        model(8);
        for (int i = 0; i < ph_q.size(); i++)
            if (ph_q[i].pr == 1'b0) begin ph_q.delete(i); break; end
        busy_fall = base + 6;
        drive_phase();

        for (int p = 0; p < 6; p++) begin
            int off = 0;
            clear_phase();
            for (int t = 0; t < 80; t++)
                if ($urandom_range(0, 4) == 0)
                    add_live(t, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1) == 1);
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
                off += $urandom_range(0, 12);
                add_ent(off, $urandom_range(0, 15), $urandom_range(0, 7));
            end
            run_phase(80);
        end

        repeat (5) begin @(posedge clk); #1; end
        check("leftover_expected_writes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
